// File: rtl/gcd_pkg.sv
// Shared types and defaults for the gcd_top initiator (sequencer FSM states,
// default operand width and watchdog limit).
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        START,
        WAIT,
        RESP
    } state_t;

    localparam int W_DEFAULT       = 10;
    localparam int TIMEOUT_DEFAULT = 2048;

endpackage

// File: rtl/gcd_sequencer_if.sv
// Host request/response handshake plus the gcd_top pin bundle driven by the
// sequencer. slave = sequencer view, master = host + core view.
interface gcd_sequencer_if
    import gcd_pkg::*;
#(
    parameter int W = W_DEFAULT
) ();

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_gcd;
    logic         rsp_err;
    logic         busy;
    logic         core_rst;
    logic         core_start;
    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic [W-1:0] core_out;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, core_out,
        output req_ready, rsp_valid, rsp_gcd, rsp_err, busy,
               core_rst, core_start, core_a, core_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, core_out,
        input  req_ready, rsp_valid, rsp_gcd, rsp_err, busy,
               core_rst, core_start, core_a, core_b
    );

endinterface

// File: rtl/gcd_watchdog.sv
// Clearable up-counter that stops at TIMEOUT-1 and flags that terminal count,
// bounding how long the sequencer waits on the core.
module gcd_watchdog
    import gcd_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc = (count_q == CNT_W'(TIMEOUT - 1));

    // Saturates instead of wrapping so a stalled FSM can never miss the limit.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gcd_sequencer.sv
// Hardware start/poll/capture initiator for gcd_top: accepts operand pairs,
// sequences core reset and start, waits for a nonzero result or a timeout.
module gcd_sequencer
    import gcd_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    gcd_sequencer_if.slave  bus
);

    state_t       state_q, state_d;
    logic         req_ready_q, req_ready_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [W-1:0] rsp_gcd_q, rsp_gcd_d;
    logic         rsp_err_q, rsp_err_d;
    logic         busy_q, busy_d;
    logic         core_rst_q, core_rst_d;
    logic         core_start_q, core_start_d;
    logic [W-1:0] core_a_q, core_a_d;
    logic [W-1:0] core_b_q, core_b_d;
    logic         wd_clr;
    logic         wd_en;
    logic         wd_tc;

    gcd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

    // Outputs are registered, so each state's output values are set on the
    // transition into that state.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_gcd_d    = rsp_gcd_q;
        rsp_err_d    = rsp_err_q;
        busy_d       = busy_q;
        core_rst_d   = core_rst_q;
        core_start_d = 1'b0;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;

        case (state_q)
            IDLE: begin
                core_rst_d  = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (bus.req_valid && req_ready_q) begin
                    core_a_d    = bus.req_a;
                    core_b_d    = bus.req_b;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    // The core never raises out for (0,0), so answer directly.
                    if (bus.req_a == '0 && bus.req_b == '0) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_gcd_d   = '0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d    = CORE_RST;
                        core_rst_d = 1'b1;
                    end
                end
            end
            CORE_RST: begin
                state_d      = START;
                core_rst_d   = 1'b0;
                core_start_d = 1'b1;
            end
            START: begin
                state_d = WAIT;
                wd_clr  = 1'b1;
            end
            WAIT: begin
                wd_en = 1'b1;
                if (bus.core_out != '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_gcd_d   = bus.core_out;
                    rsp_err_d   = 1'b0;
                end else if (wd_tc) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_gcd_d   = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Core is held in reset whenever the sequencer itself is in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_gcd_q    <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            core_rst_q   <= 1'b1;
            core_start_q <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_gcd_q    <= rsp_gcd_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            core_rst_q   <= core_rst_d;
            core_start_q <= core_start_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_gcd    = rsp_gcd_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = busy_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.core_start = core_start_q;
    assign bus.core_a     = core_a_q;
    assign bus.core_b     = core_b_q;

endmodule
